axi_lite_adc_regs: RTL and testbench

//  AXI4-Lite register slave for the ADC capture path, generalised to NUM_CH ADC channels.

---
 rtl/axi_lite_adc_regs.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_lite_adc_regs.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_adc_regs.sv
// AXI4-Lite register slave for the ADC capture path: control bits, sticky clear-on-read
// overrange flags, saturating per-channel overrange counters and a masked overrange interrupt.
module axi_lite_adc_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter int          NUM_CH             = 2,
  parameter int          CNT_WIDTH          = 16,
  parameter int          RST_PULSE_CYCLES   = 16,
  parameter logic [31:0] VERSION            = 32'h0002_0000
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [NUM_CH-1:0]               adc_or_state,
  output logic                            data_en,
  output logic                            delay_rst,
  output logic                            or_irq,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DW = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [31:0] IRQ_BITS = (32'h1 << NUM_CH) - 32'h1;
  localparam logic [31:0] CTRL_RW  = (IRQ_BITS << 16) | 32'h1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [0:0] D_OFF  = 1'b0;
  localparam logic [0:0] D_ON   = 1'b1;

  logic [0:0]           wstate_q, wstate_d;
  logic [0:0]           rstate_q, rstate_d;
  logic [0:0]           dstate_q, dstate_d;
  logic                 awready_q, awready_d;
  logic                 arready_q, arready_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [IW-1:0]        araddr_q, araddr_d;
  logic [31:0]          ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]    status_q, status_d;
  logic [NUM_CH-1:0]    edge_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic                 irq_q, irq_d;

  logic [IW-1:0] widx;
  logic          wr_fire, rd_fire;
  logic          wr_err, ctrl_wr, dly_start, cnt_clr, rd_clr;
  logic [31:0]   rd_mux;
  logic          rd_err;
  logic [NUM_CH-1:0] rise;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // awready is raised one cycle ahead; the write lands on the edge that completes the handshake
  assign widx      = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_fire   = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign wr_err    = 32'(widx) >= 32'(4 + NUM_CH);
  assign ctrl_wr   = wr_fire && (widx == '0);
  assign dly_start = ctrl_wr & s_axi_wstrb[0] & s_axi_wdata[1];
  assign cnt_clr   = ctrl_wr & s_axi_wstrb[0] & s_axi_wdata[2];

  assign rd_fire = arready_q & s_axi_arvalid;
  assign rd_clr  = rd_fire && (araddr_q == IW'(1));
  assign rise    = adc_or_state & ~edge_q;

  always_comb begin
    awready_d = 1'b0;
    wstate_d  = wstate_q;
    bresp_d   = bresp_q;
    if (wstate_q == W_IDLE) begin
      awready_d = s_axi_awvalid & s_axi_wvalid & ~awready_q;
      if (wr_fire) begin
        wstate_d = W_RESP;
        bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (s_axi_bready) begin
      wstate_d = W_IDLE;
    end
  end

  always_comb begin
    rd_mux = '0;
    rd_err = 1'b0;
    if (32'(araddr_q) >= 32'(4 + NUM_CH)) begin
      rd_err = 1'b1;
    end else if (araddr_q == IW'(0)) begin
      rd_mux = ctrl_q;
    end else if (araddr_q == IW'(1)) begin
      rd_mux = 32'(status_q);
    end else if (araddr_q == IW'(2)) begin
      rd_mux = VERSION;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (32'(araddr_q) == 4 + i) rd_mux = 32'(cnt_q[i]);
      end
    end
  end

  always_comb begin
    arready_d = 1'b0;
    rstate_d  = rstate_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (rstate_q == R_IDLE) begin
      arready_d = s_axi_arvalid & ~arready_q;
      if (s_axi_arvalid & ~arready_q) araddr_d = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
      if (rd_fire) begin
        rstate_d = R_DATA;
        rdata_d  = rd_mux;
        rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (s_axi_rready) begin
      rstate_d = R_IDLE;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) ctrl_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
      end
      ctrl_d = ctrl_d & CTRL_RW;
    end
  end

  // Clear-on-read reloads from the live input so an event in the read cycle is kept
  always_comb begin
    status_d = (rd_clr ? '0 : status_q) | adc_or_state;
    irq_d    = |(status_q & ctrl_q[16 +: NUM_CH]);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = rise[i] ? CNT_WIDTH'(1) : '0;
      end else if (rise[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    dstate_d = dstate_q;
    dcnt_d   = dcnt_q;
    if (dly_start) begin
      dstate_d = D_ON;
      dcnt_d   = DW'(RST_PULSE_CYCLES);
    end else if (dstate_q == D_ON) begin
      if (dcnt_q == DW'(1)) begin
        dstate_d = D_OFF;
        dcnt_d   = '0;
      end else begin
        dcnt_d = dcnt_q - DW'(1);
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      dstate_q  <= D_OFF;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      araddr_q  <= '0;
      ctrl_q    <= '0;
      status_q  <= '0;
      edge_q    <= '0;
      dcnt_q    <= '0;
      irq_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      dstate_q  <= dstate_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      araddr_q  <= araddr_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      edge_q    <= adc_or_state;
      dcnt_q    <= dcnt_d;
      irq_q     <= irq_d;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = (wstate_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = (rstate_q == R_DATA);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = C_S_AXI_DATA_WIDTH'(rdata_q);
  assign data_en       = ctrl_q[0];
  assign delay_rst     = (dstate_q == D_ON);
  assign or_irq        = irq_q;

endmodule

// File: tb/tb_axi_lite_adc_regs.sv
// Self-checking bench for axi_lite_adc_regs: register table, overrange flag/counter/irq
// sequences, delay_rst pulse timing and reset behaviour, with reads checked from a queue.
module tb_axi_lite_adc_regs;

  localparam int NCH = 2;
  localparam int CW  = 4;
  localparam int RPC = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adc_or_state = '0;
  logic        data_en, delay_rst, or_irq;
  logic [4:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [4:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  always #5 clk = ~clk;

  axi_lite_adc_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_CH(NCH),
    .CNT_WIDTH(CW),
    .RST_PULSE_CYCLES(RPC),
    .VERSION(32'h0002_0000)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_areset(rst),
    .adc_or_state(adc_or_state),
    .data_en(data_en),
    .delay_rst(delay_rst),
    .or_irq(or_irq),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;
  vec_t tbl[$];

  // delay_rst pulse length and the cycles of the CTRL[1] writes that produced it
  int cyc = 0, run = 0, last_run = 0, first_fire = 0, last_fire = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (delay_rst) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
    if (!rst && s_axi_awready && s_axi_awvalid && s_axi_wvalid &&
        s_axi_awaddr[4:2] == 3'd0 && s_axi_wstrb[0] && s_axi_wdata[1]) begin
      if (!delay_rst) first_fire <= cyc;
      last_fire <= cyc;
    end
  end

  logic [1:0] adc_prev_m = '0;
  int         exp_cnt[2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_adc(input logic [1:0] v);
    adc_or_state = v;
    for (int i = 0; i < 2; i++)
      if (v[i] && !adc_prev_m[i] && exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
    adc_prev_m = v;
    tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] adc_fire, input bit use_adc, output logic [1:0] resp);
    bit got;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (s_axi_awready) begin got = 1; break; end
    end
    if (!got) chk("awready_timeout", 32'(s_axi_awready), 32'd1);
    else chk("wready_pulse", 32'(s_axi_wready), 32'd1);
    if (use_adc) adc_or_state = adc_fire;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("awready_one_cycle", 32'(s_axi_awready), 32'd0);
    s_axi_bready = 1'b1;
    for (int t = 0; t < 20 && !s_axi_bvalid; t++) tick();
    if (!s_axi_bvalid) chk("bvalid_timeout", 32'(s_axi_bvalid), 32'd1);
    resp = s_axi_bresp;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] ed,
                    input logic [1:0] er, input int hold);
    exp_t e;
    bit got;
    sb.push_back('{name, ed, er});
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (s_axi_arready) begin got = 1; break; end
    end
    if (!got) chk({name, "_arready_timeout"}, 32'(s_axi_arready), 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    for (int t = 0; t < 20 && !s_axi_rvalid; t++) tick();
    e = sb.pop_front();
    if (!s_axi_rvalid) begin
      chk({e.name, "_rvalid_timeout"}, 32'(s_axi_rvalid), 32'd1);
    end else begin
      chk({e.name, "_rdata"}, s_axi_rdata, e.data);
      chk({e.name, "_rresp"}, 32'(s_axi_rresp), 32'(e.resp));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk({e.name, "_hold_rvalid"}, 32'(s_axi_rvalid), 32'd1);
        chk({e.name, "_hold_rdata"}, s_axi_rdata, e.data);
      end
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      chk({e.name, "_rvalid_drop"}, 32'(s_axi_rvalid), 32'd0);
    end
  endtask

  task automatic wait_dly_end();
    for (int t = 0; t < 80 && delay_rst; t++) tick();
    tick();
  endtask

  initial begin #300000; $display("FAIL watchdog: simulation time limit reached"); $fatal; end

  initial begin
    logic [1:0] resp;

    tbl.push_back('{1'b1, 5'h00, 32'h0003_0001, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0003_0001, 2'b00});
    tbl.push_back('{1'b0, 5'h08, 32'h0,         4'h0, 32'h0002_0000, 2'b00});
    tbl.push_back('{1'b0, 5'h0C, 32'h0,         4'h0, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h04, 32'h0,         4'h0, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h10, 32'h0,         4'h0, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h18, 32'h0,         4'h0, 32'h0, 2'b10});
    tbl.push_back('{1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10});
    tbl.push_back('{1'b1, 5'h08, 32'h0000_1234, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h08, 32'h0,         4'h0, 32'h0002_0000, 2'b00});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0003_0001, 2'b00});
    tbl.push_back('{1'b1, 5'h00, 32'h0000_0000, 4'b0001, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0003_0000, 2'b00});
    tbl.push_back('{1'b1, 5'h00, 32'hFFFC_FFFE, 4'b0100, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0000, 2'b00});
    tbl.push_back('{1'b1, 5'h00, 32'h0001_0001, 4'b0101, 32'h0, 2'b00});
    tbl.push_back('{1'b1, 5'h00, 32'hFFFF_FFF9, 4'b1010, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0001_0001, 2'b00});
    tbl.push_back('{1'b1, 5'h00, 32'h0003_0001, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 32'h0003_0001, 2'b00});

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    chk("rst_rdata",   s_axi_rdata,        32'd0);
    chk("rst_outputs", {29'd0, data_en, delay_rst, or_irq}, 32'd0);
    rst = 1'b0;
    tick();

    // Reset lands on the cycle the handshake would complete
    s_axi_awaddr = 5'h00; s_axi_wdata = 32'h0003_0003; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    for (int t = 0; t < 20 && !s_axi_awready; t++) tick();
    chk("midwr_awready_seen", 32'(s_axi_awready), 32'd1);
    rst = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("midwr_ready_dropped", {30'd0, s_axi_awready, s_axi_wready}, 32'd0);
    chk("midwr_bvalid", 32'(s_axi_bvalid), 32'd0);
    rst = 1'b0;
    tick();
    chk("midwr_bvalid_after", 32'(s_axi_bvalid), 32'd0);
    chk("midwr_data_en", {30'd0, data_en, delay_rst}, 32'd0);
    rd("midwr_ctrl", 5'h00, 32'h0, 2'b00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].data, tbl[i].strb, 2'b00, 1'b0, resp);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(tbl[i].resp));
      end else begin
        rd($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp, tbl[i].resp, 0);
      end
    end
    chk("data_en_port", 32'(data_en), 32'd1);

    wr(5'h00, 32'h0003_0003, 4'hF, 2'b00, 1'b0, resp);
    chk("dly_started", 32'(delay_rst), 32'd1);
    wait_dly_end();
    chk("dly_len", 32'(last_run), 32'(RPC));
    wr(5'h00, 32'h0003_0003, 4'hF, 2'b00, 1'b0, resp);
    repeat (4) tick();
    wr(5'h00, 32'h0003_0003, 4'hF, 2'b00, 1'b0, resp);
    wait_dly_end();
    chk("dly_refire_seen", 32'(last_fire > first_fire), 32'd1);
    chk("dly_ext_len", 32'(last_run), 32'(last_fire - first_fire + RPC));
    rd("ctrl_bit1_reads0", 5'h00, 32'h0003_0001, 2'b00, 0);

    for (int k = 0; k < 3; k++) begin
      drive_adc(2'b10); drive_adc(2'b00); drive_adc(2'b00);
    end
    tick();
    chk("irq_set", 32'(or_irq), 32'd1);
    rd("cnt1_three", 5'h14, 32'd3, 2'b00, 0);
    rd("status_first", 5'h04, 32'h2, 2'b00, 0);
    repeat (2) tick();
    chk("irq_clear", 32'(or_irq), 32'd0);
    rd("status_second", 5'h04, 32'h0, 2'b00, 0);

    drive_adc(2'b01);
    rd("status_held_a", 5'h04, 32'h1, 2'b00, 0);
    rd("status_held_b", 5'h04, 32'h1, 2'b00, 0);
    rd("cnt0_held", 5'h10, 32'(exp_cnt[0]), 2'b00, 0);
    drive_adc(2'b00);
    rd("status_after_hold", 5'h04, 32'h1, 2'b00, 0);
    rd("status_cleared", 5'h04, 32'h0, 2'b00, 0);

    wr(5'h00, 32'h0002_0001, 4'hF, 2'b00, 1'b0, resp);
    drive_adc(2'b01); drive_adc(2'b00);
    repeat (2) tick();
    chk("irq_masked", 32'(or_irq), 32'd0);
    wr(5'h00, 32'h0001_0001, 4'hF, 2'b00, 1'b0, resp);
    chk("irq_unmasked", 32'(or_irq), 32'd1);
    rd("status_masked_ch0", 5'h04, 32'h1, 2'b00, 0);
    wr(5'h00, 32'h0003_0001, 4'hF, 2'b00, 1'b0, resp);

    for (int k = 0; k < 20; k++) begin
      drive_adc(2'b10); drive_adc(2'b00);
    end
    rd("cnt1_saturated", 5'h14, 32'(exp_cnt[1]), 2'b00, 5);
    rd("cnt0_unsat", 5'h10, 32'(exp_cnt[0]), 2'b00, 0);
    rd("status_sat", 5'h04, 32'h2, 2'b00, 0);

    // Counter clear and a ch0 rising edge land on the same edge
    wr(5'h00, 32'h0003_0005, 4'hF, 2'b01, 1'b1, resp);
    chk("cntclr_bresp", 32'(resp), 32'd0);
    exp_cnt[0] = 1; exp_cnt[1] = 0; adc_prev_m = 2'b01;
    drive_adc(2'b00);
    rd("cntclr_cnt0_edge", 5'h10, 32'(exp_cnt[0]), 2'b00, 0);
    rd("cntclr_cnt1", 5'h14, 32'(exp_cnt[1]), 2'b00, 0);
    rd("ctrl_bit2_reads0", 5'h00, 32'h0003_0001, 2'b00, 0);

    // Reset with state populated and ch1 level held high through it
    drive_adc(2'b10);
    tick();
    chk("pre_rst_irq", 32'(or_irq), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst2_outputs", {29'd0, data_en, delay_rst, or_irq}, 32'd0);
    chk("rst2_rdata", s_axi_rdata, 32'd0);
    rst = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0; adc_prev_m = 2'b00;
    drive_adc(2'b10);
    drive_adc(2'b00);
    rd("rst2_cnt1_level", 5'h14, 32'(exp_cnt[1]), 2'b00, 0);
    rd("rst2_cnt0", 5'h10, 32'd0, 2'b00, 0);
    rd("rst2_ctrl", 5'h00, 32'd0, 2'b00, 0);
    rd("rst2_status", 5'h04, 32'h2, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
